// File: rtl/decode_issue_ctrl.sv
// Decode/issue control: single-entry pipeline register between fetch and execute,
// with immediate decode at capture, load-use stall detection and flush handling.
module decode_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IF_VALID,
  input  logic [31:0]      IF_IR,
  input  logic [31:0]      IF_PC,
  output logic             IF_READY,
  output logic             ID_VALID,
  input  logic             EX_READY,
  output logic [31:0]      ID_IR,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_IMM,
  output logic [2:0]       ID_IMM_TYPE,
  output logic             ID_ILLEGAL,
  input  logic             FLUSH,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_RD,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {EMPTY, FULL, KILL} state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [6:0]  held_op;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        issue;
  logic        capture;
  logic [31:0] dec_imm;
  logic [2:0]  dec_type;
  logic        dec_illegal;

  assign held_op = ID_IR[6:0];

  always_comb begin
    uses_rs1 = !((held_op == OP_LUI) || (held_op == OP_AUIPC) || (held_op == OP_JAL));
    uses_rs2 = (held_op == OP_REG) || (held_op == OP_STORE) || (held_op == OP_BRANCH);
    hazard   = EX_MEMREAD && (EX_RD != 5'd0) &&
               ((uses_rs1 && (ID_IR[19:15] == EX_RD)) ||
                (uses_rs2 && (ID_IR[24:20] == EX_RD)));
  end

  // A flush or reset in flight suppresses the offer so nothing issues that cycle.
  assign ID_VALID = (state == FULL) && !hazard && !FLUSH && !RST;
  assign issue    = ID_VALID && EX_READY;
  assign IF_READY = (state == FULL) ? issue : 1'b1;
  assign capture  = IF_VALID && IF_READY;

  always_comb begin
    dec_imm     = 32'd0;
    dec_type    = 3'd0;
    dec_illegal = 1'b0;
    case (IF_IR[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_type = 3'd1;
        dec_imm  = {{20{IF_IR[31]}}, IF_IR[31:20]};
      end
      OP_STORE: begin
        dec_type = 3'd2;
        dec_imm  = {{20{IF_IR[31]}}, IF_IR[31:25], IF_IR[11:7]};
      end
      OP_BRANCH: begin
        dec_type = 3'd3;
        dec_imm  = {{19{IF_IR[31]}}, IF_IR[31], IF_IR[7], IF_IR[30:25], IF_IR[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_type = 3'd4;
        dec_imm  = {IF_IR[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_type = 3'd5;
        dec_imm  = {{11{IF_IR[31]}}, IF_IR[31], IF_IR[19:12], IF_IR[20], IF_IR[30:21], 1'b0};
      end
      OP_REG: dec_type = 3'd0;
      default: dec_illegal = 1'b1;
    endcase
  end

  // KILL swallows whatever fetch delivers in its single cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= EMPTY;
      ID_IR       <= 32'd0;
      ID_PC       <= 32'd0;
      ID_IMM      <= 32'd0;
      ID_IMM_TYPE <= 3'd0;
      ID_ILLEGAL  <= 1'b0;
      STALL_CNT   <= '0;
      FLUSH_CNT   <= '0;
    end else if (FLUSH) begin
      state <= KILL;
      if (FLUSH_CNT != '1) FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
    end else begin
      if ((state == FULL) && hazard && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + CNT_ONE;
      case (state)
        EMPTY, FULL: begin
          if (capture) begin
            state       <= FULL;
            ID_IR       <= IF_IR;
            ID_PC       <= IF_PC;
            ID_IMM      <= dec_imm;
            ID_IMM_TYPE <= dec_type;
            ID_ILLEGAL  <= dec_illegal;
          end else if (issue) begin
            state <= EMPTY;
          end
        end
        KILL:    state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: a slot-level behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_decode_issue_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST, IF_VALID, EX_READY, FLUSH, EX_MEMREAD;
  logic [31:0]   IF_IR, IF_PC;
  logic [4:0]    EX_RD;
  logic          IF_READY, ID_VALID, ID_ILLEGAL;
  logic [31:0]   ID_IR, ID_PC, ID_IMM;
  logic [2:0]    ID_IMM_TYPE;
  logic [CW-1:0] STALL_CNT, FLUSH_CNT;

  int compared = 0;
  int mismatched = 0;

  decode_issue_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .IF_VALID(IF_VALID), .IF_IR(IF_IR), .IF_PC(IF_PC), .IF_READY(IF_READY),
    .ID_VALID(ID_VALID), .EX_READY(EX_READY),
    .ID_IR(ID_IR), .ID_PC(ID_PC), .ID_IMM(ID_IMM), .ID_IMM_TYPE(ID_IMM_TYPE),
    .ID_ILLEGAL(ID_ILLEGAL),
    .FLUSH(FLUSH), .EX_MEMREAD(EX_MEMREAD), .EX_RD(EX_RD),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model of the slot: 0 = empty, 1 = holding, 2 = discarding one fetch.
  int          m_slot, n_slot;
  bit          m_started = 0;
  logic [31:0] m_ir, m_pc, m_imm, n_ir, n_pc, n_imm;
  logic [2:0]  m_type, n_type;
  logic        m_ill, n_ill;
  int          m_stall, m_flush, n_stall, n_flush;
  logic [31:0] dut_issued[$];

  function automatic logic [31:0] sx(input int w, input logic [31:0] v);
    logic signed [31:0] t;
    t = v << (32 - w);
    return t >>> (32 - w);
  endfunction

  function automatic void decode(input logic [31:0] ir, output logic [2:0] typ,
                                 output logic [31:0] imm, output logic ill);
    typ = 3'd0; imm = 32'd0; ill = 1'b0;
    case (ir[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin typ = 3'd1; imm = sx(12, 32'(ir[31:20])); end
      7'h23: begin typ = 3'd2; imm = sx(12, 32'({ir[31:25], ir[11:7]})); end
      7'h63: begin typ = 3'd3; imm = sx(13, 32'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0})); end
      7'h37, 7'h17: begin typ = 3'd4; imm = ir & 32'hFFFFF000; end
      7'h6F: begin typ = 3'd5; imm = sx(21, 32'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0})); end
      7'h33: typ = 3'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int satInc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  always @(negedge CLK) begin
    bit rs1_used, rs2_used, exp_haz, exp_idv, exp_ifr, take, send;
    if (m_started) begin
      rs1_used = !(m_ir[6:0] inside {7'h37, 7'h17, 7'h6F});
      rs2_used = m_ir[6:0] inside {7'h33, 7'h23, 7'h63};
      exp_haz  = (m_slot == 1) && EX_MEMREAD && (EX_RD != 0) &&
                 ((rs1_used && m_ir[19:15] == EX_RD) || (rs2_used && m_ir[24:20] == EX_RD));
      exp_idv  = (m_slot == 1) && !exp_haz && !FLUSH && !RST;
      send     = exp_idv && EX_READY;
      exp_ifr  = (m_slot == 1) ? send : 1'b1;
      checkOutput("id_valid", 32'(ID_VALID), 32'(exp_idv));
      checkOutput("if_ready", 32'(IF_READY), 32'(exp_ifr));
      checkOutput("stall_cnt", 32'(STALL_CNT), 32'(m_stall));
      checkOutput("flush_cnt", 32'(FLUSH_CNT), 32'(m_flush));
      if (m_slot == 1) begin
        checkOutput("id_ir", ID_IR, m_ir);
        checkOutput("id_pc", ID_PC, m_pc);
        checkOutput("id_imm", ID_IMM, m_imm);
        checkOutput("id_imm_type", 32'(ID_IMM_TYPE), 32'(m_type));
        checkOutput("id_illegal", 32'(ID_ILLEGAL), 32'(m_ill));
      end
      if (ID_VALID && EX_READY) dut_issued.push_back(ID_PC);
      n_slot = m_slot; n_ir = m_ir; n_pc = m_pc; n_imm = m_imm; n_type = m_type;
      n_ill = m_ill; n_stall = m_stall; n_flush = m_flush;
      if (FLUSH) begin
        n_slot  = 2;
        n_flush = satInc(m_flush);
      end else begin
        if (exp_haz) n_stall = satInc(m_stall);
        take = IF_VALID && exp_ifr && (m_slot != 2);
        if (take) begin
          n_slot = 1; n_ir = IF_IR; n_pc = IF_PC;
          decode(IF_IR, n_type, n_imm, n_ill);
        end else if (send || m_slot == 2) begin
          n_slot = 0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_slot = 0; m_ir = 0; m_pc = 0; m_imm = 0; m_type = 0; m_ill = 0;
      m_stall = 0; m_flush = 0;
    end else if (m_started) begin
      m_slot = n_slot; m_ir = n_ir; m_pc = n_pc; m_imm = n_imm; m_type = n_type;
      m_ill = n_ill; m_stall = n_stall; m_flush = n_flush;
    end
    m_started = 1;
  end

  task automatic applyStimulus(input logic rst, input logic ifv, input logic [31:0] ir,
                               input logic [31:0] pc, input logic exr, input logic fl,
                               input logic mr, input logic [4:0] rd);
    @(posedge CLK);
    #1;
    RST = rst; IF_VALID = ifv; IF_IR = ir; IF_PC = pc; EX_READY = exr;
    FLUSH = fl; EX_MEMREAD = mr; EX_RD = rd;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_id_ir"}, ID_IR, 32'd0);
    checkOutput({tag, "_id_pc"}, ID_PC, 32'd0);
    checkOutput({tag, "_id_imm"}, ID_IMM, 32'd0);
    checkOutput({tag, "_imm_type"}, 32'(ID_IMM_TYPE), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(ID_ILLEGAL), 32'd0);
    checkOutput({tag, "_stall_cnt"}, 32'(STALL_CNT), 32'd0);
    checkOutput({tag, "_flush_cnt"}, 32'(FLUSH_CNT), 32'd0);
    checkOutput({tag, "_id_valid"}, 32'(ID_VALID), 32'd0);
    checkOutput({tag, "_if_ready"}, 32'(IF_READY), 32'd1);
  endtask

  initial begin
    RST = 1; IF_VALID = 0; IF_IR = 0; IF_PC = 0; EX_READY = 0;
    FLUSH = 0; EX_MEMREAD = 0; EX_RD = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkResetState("reset");

    // addi x1,x0,-1 held while execute is busy
    applyStimulus(0, 1, 32'hFFF00093, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("addi_valid", 32'(ID_VALID), 32'd1);
    checkOutput("addi_imm", ID_IMM, 32'hFFFFFFFF);
    checkOutput("addi_type", 32'(ID_IMM_TYPE), 32'd1);
    checkOutput("addi_if_ready", 32'(IF_READY), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("addi_held_ir", ID_IR, 32'hFFF00093);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("addi_issue_ready", 32'(IF_READY), 32'd1);

    // beq then lui back to back
    applyStimulus(0, 1, 32'hFE000EE3, 32'h104, 1, 0, 0, 0);
    applyStimulus(0, 1, 32'h123452B7, 32'h108, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("beq_imm", ID_IMM, 32'hFFFFFFFC);
    checkOutput("beq_type", 32'(ID_IMM_TYPE), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lui_imm", ID_IMM, 32'h12345000);
    checkOutput("lui_type", 32'(ID_IMM_TYPE), 32'd4);

    // add x3,x5,x6 behind a load to x5
    applyStimulus(0, 1, 32'h006281B3, 32'h10C, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'h00100093, 32'h1F0, 1, 0, 1, 5'd5);
      @(negedge CLK);
      checkOutput("stall_valid", 32'(ID_VALID), 32'd0);
      checkOutput("stall_if_ready", 32'(IF_READY), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 5'd0);
    @(negedge CLK);
    checkOutput("rd0_no_stall", 32'(ID_VALID), 32'd1);
    checkOutput("stall_cnt_2", 32'(STALL_CNT), 32'd2);

    // flush while holding, with fetch still pushing
    applyStimulus(0, 1, 32'h00100093, 32'h110, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h00200093, 32'h114, 1, 1, 0, 0);
    @(negedge CLK);
    checkOutput("flush_no_issue", 32'(ID_VALID), 32'd0);
    applyStimulus(0, 1, 32'h00300093, 32'h200, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("kill_if_ready", 32'(IF_READY), 32'd1);
    checkOutput("kill_valid", 32'(ID_VALID), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("after_kill_valid", 32'(ID_VALID), 32'd0);
    checkOutput("flush_cnt_1", 32'(FLUSH_CNT), 32'd1);

    // flush arriving again during KILL
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 32'h00400093, 32'h204, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("double_kill_valid", 32'(ID_VALID), 32'd0);
    checkOutput("flush_cnt_3", 32'(FLUSH_CNT), 32'd3);

    // ten-instruction stream with no bubbles
    for (int i = 0; i < 11; i++) begin
      if (i < 10) applyStimulus(0, 1, 32'h00000013 | (32'(i) << 20), 32'h300 + 32'(4 * i), 1, 0, 0, 0);
      else        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      if (i == 0) dut_issued.delete();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stream_issue_count", 32'(dut_issued.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < dut_issued.size()) checkOutput("stream_order", dut_issued[i], 32'h300 + 32'(4 * i));
    end

    // unrecognised opcode, then saturate the stall counter on its rs1 (x31)
    applyStimulus(0, 1, 32'hFFFFFFFF, 32'h400, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("illegal_flag", 32'(ID_ILLEGAL), 32'd1);
    checkOutput("illegal_imm", ID_IMM, 32'd0);
    checkOutput("illegal_type", 32'(ID_IMM_TYPE), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1, 5'd31);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("stall_saturated", 32'(STALL_CNT), 32'hF);

    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    checkOutput("flush_saturated", 32'(FLUSH_CNT), 32'hF);

    // reset beats a flush and a live transfer
    applyStimulus(0, 1, 32'h00500093, 32'h500, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h00600093, 32'h504, 1, 1, 0, 0);
    @(negedge CLK);
    checkOutput("reset_mid_valid", 32'(ID_VALID), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkResetState("reset_mid");

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
